// File: rtl/dffram_fifo_ctrl.sv
// Streaming FIFO controller for a 256x16 2R1W latch DFFRAM: port 0 writes, port 1 reads,
// and a 2-entry output buffer absorbs the one-cycle RAM read latency.
module dffram_fifo_ctrl #(
  parameter int AW    = 8,
  parameter int DEPTH = 256,
  parameter int DW    = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic [AW:0]       count,
  output logic [DW/8-1:0]   ram_we0,
  output logic              ram_en0,
  output logic [AW-1:0]     ram_a0,
  output logic [DW-1:0]     ram_di0,
  output logic              ram_en1,
  output logic [AW-1:0]     ram_a1,
  input  logic [DW-1:0]     ram_do1
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   ram_cnt, ram_cnt_n;
  logic          inflight;
  logic [1:0]    obuf_cnt, obuf_cnt_n;
  logic [DW-1:0] head, tail;
  logic          push, pop, issue;
  logic [2:0]    pend;

  // s_ready looks only at registered occupancy; a slot freed by a same-cycle read shows up next cycle
  assign s_ready = !RST && (ram_cnt < DEPTH_C);
  assign push    = s_valid && s_ready;
  assign m_valid = (obuf_cnt != 2'd0);
  assign m_data  = head;
  assign pop     = m_valid && m_ready;

  assign pend  = 3'(obuf_cnt) + 3'(inflight) - 3'(pop);
  assign issue = (ram_cnt != '0) && (pend < 3'd2);

  assign ram_en0 = push;
  assign ram_we0 = {(DW/8){push}};
  assign ram_a0  = wptr;
  assign ram_di0 = s_data;
  assign ram_en1 = issue;
  assign ram_a1  = rptr;

  always_comb begin
    ram_cnt_n = ram_cnt + (AW+1)'(push) - (AW+1)'(issue);
    obuf_cnt_n = obuf_cnt;
    case ({inflight, pop})
      2'b10:   obuf_cnt_n = obuf_cnt + 2'd1;
      2'b01:   obuf_cnt_n = obuf_cnt - 2'd1;
      default: obuf_cnt_n = obuf_cnt;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
      obuf_cnt <= '0;
      count    <= '0;
    end else begin
      if (push)  wptr <= wptr + AW'(1);
      if (issue) rptr <= rptr + AW'(1);
      ram_cnt  <= ram_cnt_n;
      inflight <= issue;
      obuf_cnt <= obuf_cnt_n;
      count    <= ram_cnt_n + (AW+1)'(issue) + (AW+1)'(obuf_cnt_n);
    end
  end

  // Output buffer: capture from ram_do1 lands behind whatever survives this cycle's pop
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
    end else if (inflight && pop) begin
      if (obuf_cnt == 2'd2) begin
        head <= tail;
        tail <= ram_do1;
      end else begin
        head <= ram_do1;
      end
    end else if (inflight) begin
      if (obuf_cnt == 2'd0) head <= ram_do1;
      else                  tail <= ram_do1;
    end else if (pop) begin
      head <= tail;
    end
  end

endmodule

// File: tb/tb_dffram_fifo_ctrl.sv
// Bench for dffram_fifo_ctrl: behavioural RAM model, scoreboard queue fed on accepted pushes,
// monitor popping and comparing on every output transfer.
module tb_dffram_fifo_ctrl;

  logic        CLK, RST;
  logic        s_valid, s_ready, m_valid, m_ready;
  logic [15:0] s_data, m_data, ram_di0, ram_do1;
  logic [8:0]  count;
  logic [1:0]  ram_we0;
  logic        ram_en0, ram_en1;
  logic [7:0]  ram_a0, ram_a1;

  logic [15:0] mem [256];
  logic [15:0] expq [$];
  logic [15:0] exp_d, hold_data;
  logic        hold;
  int          n_chk = 0, n_fail = 0;

  dffram_fifo_ctrl #(.AW(8), .DEPTH(256), .DW(16)) dut (
    .CLK(CLK), .RST(RST),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .count(count),
    .ram_we0(ram_we0), .ram_en0(ram_en0), .ram_a0(ram_a0), .ram_di0(ram_di0),
    .ram_en1(ram_en1), .ram_a1(ram_a1), .ram_do1(ram_do1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) begin
    if (ram_en0 && ram_we0 == 2'b11) mem[ram_a0] <= ram_di0;
    if (ram_en1) ram_do1 <= mem[ram_a1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor on the falling edge, where all handshakes for the next rising edge are settled
  always @(negedge CLK) begin
    if (RST) begin
      expq.delete();
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("stall_mvalid", m_valid, 1);
        check("stall_mdata", m_data, hold_data);
      end
      check("count_vs_model", count, expq.size());
      if (m_valid && m_ready) begin
        if (expq.size() == 0) check("unexpected_output", 1, 0);
        else begin
          exp_d = expq.pop_front();
          check("m_data", m_data, exp_d);
        end
      end
      if (s_valid && s_ready) expq.push_back(s_data);
      hold      = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_outs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_m_data"},  m_data,  0);
    check({tag, "_count"},   count,   0);
    check({tag, "_ram_en0"}, ram_en0, 0);
    check({tag, "_ram_we0"}, ram_we0, 0);
    check({tag, "_ram_en1"}, ram_en1, 0);
    check({tag, "_ram_a0"},  ram_a0,  0);
    check({tag, "_ram_a1"},  ram_a1,  0);
  endtask

  task automatic drain(input string tag);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 600 && (count != 0 || m_valid); i++) tick;
    tick;
    check({tag, "_count"},   count, 0);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_queue"},   expq.size(), 0);
  endtask

  int acc, pushed, pops, gaps, refused;
  bit seen, stall;

  initial begin
    RST = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #3;
    chk_reset_outs("por");
    tick; tick;
    RST = 1'b0;
    tick;

    // Latency: single word into an empty FIFO
    s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
    #1;
    check("lat_s_ready", s_ready, 1);
    check("lat_ram_en0", ram_en0, 1);
    check("lat_ram_we0", ram_we0, 2'b11);
    check("lat_ram_a0",  ram_a0, 0);
    tick;
    s_valid = 1'b0;
    check("lat_ram_en1_n", ram_en1, 1);
    check("lat_ram_a1_n",  ram_a1, 0);
    check("lat_count_n",   count, 1);
    check("lat_mvalid_n",  m_valid, 0);
    tick;
    check("lat_ram_en1_n1", ram_en1, 0);
    check("lat_count_n1",   count, 1);
    check("lat_mvalid_n1",  m_valid, 0);
    tick;
    check("lat_mvalid_n2", m_valid, 1);
    check("lat_mdata_n2",  m_data, 16'h1234);
    check("lat_count_n2",  count, 1);
    tick;
    check("lat_count_n3",  count, 0);
    check("lat_mvalid_n3", m_valid, 0);

    // Reset mid-stream with five words held
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'h0100 + 16'(i);
      tick;
    end
    s_valid = 1'b0;
    tick; tick;
    check("rst_pre_count", count, 5);
    #3;
    RST = 1'b1; s_valid = 1'b1; s_data = 16'h7777;
    #1;
    chk_reset_outs("rst_mid");
    s_valid = 1'b0;
    tick; tick;
    #2;
    RST = 1'b0;
    #1;
    check("rst_rel_s_ready", s_ready, 1);
    tick;
    s_valid = 1'b1; s_data = 16'hA5A5;
    tick;
    s_valid = 1'b0;
    tick;
    check("rst_a5_mvalid_e1", m_valid, 0);
    tick;
    check("rst_a5_mvalid_e2", m_valid, 1);
    check("rst_a5_mdata_e2",  m_data, 16'hA5A5);
    drain("rst_drain");

    // Fill with the output stalled, then the simultaneous pop/push at full
    m_ready = 1'b0; acc = 0;
    for (int i = 0; i < 260; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      if (s_ready) acc++;
      tick;
    end
    s_valid = 1'b0;
    check("fill_accepted", acc, 258);
    check("fill_count",    count, 258);
    check("fill_s_ready",  s_ready, 0);
    check("fill_mdata",    m_data, 16'h0000);
    m_ready = 1'b1; s_valid = 1'b1; s_data = 16'hBEEF;
    #1;
    check("full_edge_refuse", s_ready, 0);
    tick;
    m_ready = 1'b0;
    check("full_edge_next_ready", s_ready, 1);
    check("full_edge_count_a", count, 257);
    tick;
    s_valid = 1'b0;
    check("full_edge_count_b", count, 258);
    drain("fill_drain");

    // Streaming: 1000 words back to back, output must never gap once primed
    pushed = 0; pops = 0; gaps = 0; refused = 0; seen = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 1200 && pops < 1000; c++) begin
      s_valid = (pushed < 1000);
      s_data  = 16'(pushed);
      if (s_valid && s_ready) pushed++;
      if (s_valid && !s_ready) refused++;
      if (m_valid) begin
        seen = 1'b1;
        pops++;
      end else if (seen) gaps++;
      tick;
    end
    s_valid = 1'b0;
    check("stream_pushed",  pushed, 1000);
    check("stream_pops",    pops, 1000);
    check("stream_gaps",    gaps, 0);
    check("stream_refused", refused, 0);
    drain("stream_drain");

    // Random valid/ready stalls; s_data held while an offer is pending
    s_valid = 1'b0; stall = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      if (!stall) begin
        s_valid = 1'($urandom_range(0, 1));
        s_data  = 16'($urandom);
      end
      m_ready = 1'($urandom_range(0, 1));
      stall = s_valid && !s_ready;
      tick;
    end
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
